// File: rtl/fmb_pkg.sv
// Shared types and constants for the find_best_neighbor next-hop selector.
package fmb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARMED,
    S_CNT,
    S_RD_ID,
    S_RD_HOP,
    S_RD_Q,
    S_RD_E,
    S_EVAL,
    S_DONE
  } state_t;

  // Default node-memory layout of the neighbour tables
  localparam logic [10:0] DEF_NCOUNT_ADDR = 11'h2C4;
  localparam logic [10:0] DEF_ID_BASE     = 11'h0F2;
  localparam logic [10:0] DEF_HOPS_BASE   = 11'h132;
  localparam logic [10:0] DEF_Q_BASE      = 11'h172;
  localparam logic [10:0] DEF_E_BASE      = 11'h1B2;

  // Fill bits for the best registers after reset/start: Q cleared,
  // hops and ID saturated so any real candidate compares as better.
  localparam bit BEST_Q_RST_BIT   = 1'b0;
  localparam bit BEST_KEY_RST_BIT = 1'b1;

endpackage

// File: rtl/find_best_neighbor_nbr_compare.sv
// Combinational lexicographic comparator: higher Q wins, then fewer hops,
// then lower ID. A full tie reports "not better" so the incumbent stays.
module nbr_compare #(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic [WORD_WIDTH-1:0] cand_q_i,
  input  logic [WORD_WIDTH-1:0] cand_hops_i,
  input  logic [WORD_WIDTH-1:0] cand_id_i,
  input  logic [WORD_WIDTH-1:0] best_q_i,
  input  logic [WORD_WIDTH-1:0] best_hops_i,
  input  logic [WORD_WIDTH-1:0] best_id_i,
  input  logic                  best_valid_i,
  output logic                  better_o
);

  logic q_gt, q_eq, h_lt, h_eq, id_lt;

  assign q_gt  = cand_q_i > best_q_i;
  assign q_eq  = cand_q_i == best_q_i;
  assign h_lt  = cand_hops_i < best_hops_i;
  assign h_eq  = cand_hops_i == best_hops_i;
  assign id_lt = cand_id_i < best_id_i;

  assign better_o = !best_valid_i || q_gt || (q_eq && h_lt) || (q_eq && h_eq && id_lt);

endmodule

// File: rtl/find_best_neighbor.sv
// Next-hop selector: scans the neighbour tables in node memory and returns
// the best neighbour (max Q, then min hops, then min ID).
// Optional feature macro: FMB_ENERGY_FILTER_EN adds the min_energy port and
// an energy fetch per entry; entries below min_energy are never accepted.
module find_best_neighbor
  import fmb_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH    = 16,
  parameter int unsigned           ADDR_WIDTH    = 11,
  parameter int unsigned           MAX_NEIGHBORS = 32,
  parameter logic [ADDR_WIDTH-1:0] NCOUNT_ADDR   = DEF_NCOUNT_ADDR,
  parameter logic [ADDR_WIDTH-1:0] ID_BASE       = DEF_ID_BASE,
  parameter logic [ADDR_WIDTH-1:0] HOPS_BASE     = DEF_HOPS_BASE,
  parameter logic [ADDR_WIDTH-1:0] Q_BASE        = DEF_Q_BASE,
  parameter logic [ADDR_WIDTH-1:0] E_BASE        = DEF_E_BASE,
  parameter int unsigned           STRIDE        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            data_in,
`ifdef FMB_ENERGY_FILTER_EN
  input  logic [WORD_WIDTH-1:0]            min_energy,
`endif
  output logic [ADDR_WIDTH-1:0]            address,
  output logic                             busy,
  output logic                             done,
  output logic                             best_valid,
  output logic [WORD_WIDTH-1:0]            best_id,
  output logic [WORD_WIDTH-1:0]            best_q,
  output logic [WORD_WIDTH-1:0]            best_hops,
  output logic [$clog2(MAX_NEIGHBORS)-1:0] best_idx,
  output logic                             count_clamped
);

  localparam int IDX_W = $clog2(MAX_NEIGHBORS);
  localparam int CNT_W = $clog2(MAX_NEIGHBORS + 1);

  localparam logic [WORD_WIDTH-1:0] Q_RST   = {WORD_WIDTH{BEST_Q_RST_BIT}};
  localparam logic [WORD_WIDTH-1:0] KEY_RST = {WORD_WIDTH{BEST_KEY_RST_BIT}};

  // Table entry address; wraps inside the address space with no carry out
  function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [IDX_W-1:0]      i);
    return base + ADDR_WIDTH'(i) * ADDR_WIDTH'(STRIDE);
  endfunction

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    busy_q, done_q, valid_q, clamped_q;
  logic [WORD_WIDTH-1:0]   bq_q, bhops_q, bid_q;
  logic [IDX_W-1:0]        bidx_q, idx_q, idx_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic [WORD_WIDTH-1:0]   cand_id_q, cand_hops_q, cand_q_q;
  logic                    over_max, is_last, better, eligible, accept;

  assign over_max = data_in > WORD_WIDTH'(MAX_NEIGHBORS);
  assign n_d      = over_max ? CNT_W'(MAX_NEIGHBORS) : CNT_W'(data_in);
  assign idx_d    = idx_q + IDX_W'(1);
  assign is_last  = CNT_W'(idx_q) == (n_q - CNT_W'(1));

  nbr_compare #(.WORD_WIDTH(WORD_WIDTH)) u_cmp (
    .cand_q_i     (cand_q_q),
    .cand_hops_i  (cand_hops_q),
    .cand_id_i    (cand_id_q),
    .best_q_i     (bq_q),
    .best_hops_i  (bhops_q),
    .best_id_i    (bid_q),
    .best_valid_i (valid_q),
    .better_o     (better)
  );

`ifdef FMB_ENERGY_FILTER_EN
  logic [WORD_WIDTH-1:0] cand_e_q;
  assign eligible = cand_e_q >= min_energy;
`else
  assign eligible = 1'b1;
`endif

  assign accept = eligible && better;

  // Latch each fetched field of the current candidate (data path, no reset)
  always_ff @(posedge clk) begin
    if (state_q == S_RD_ID)  cand_id_q   <= data_in;
    if (state_q == S_RD_HOP) cand_hops_q <= data_in;
    if (state_q == S_RD_Q)   cand_q_q    <= data_in;
`ifdef FMB_ENERGY_FILTER_EN
    if (state_q == S_RD_E)   cand_e_q    <= data_in;
`endif
  end

  // Scan FSM with registered address, status and winner outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      bq_q      <= Q_RST;
      bhops_q   <= KEY_RST;
      bid_q     <= KEY_RST;
      bidx_q    <= '0;
      clamped_q <= 1'b0;
      idx_q     <= '0;
      n_q       <= '0;
    end else if (!en) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: state_q <= S_ARMED;
        S_ARMED: begin
          if (start) begin
            state_q   <= S_CNT;
            addr_q    <= NCOUNT_ADDR;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            bq_q      <= Q_RST;
            bhops_q   <= KEY_RST;
            bid_q     <= KEY_RST;
            bidx_q    <= '0;
            clamped_q <= 1'b0;
          end
        end
        S_CNT: begin
          n_q       <= n_d;
          clamped_q <= over_max;
          if (data_in == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RD_ID;
            addr_q  <= entry_addr(ID_BASE, idx_q);
          end
        end
        S_RD_ID: begin
          state_q <= S_RD_HOP;
          addr_q  <= entry_addr(HOPS_BASE, idx_q);
        end
        S_RD_HOP: begin
          state_q <= S_RD_Q;
          addr_q  <= entry_addr(Q_BASE, idx_q);
        end
        S_RD_Q: begin
`ifdef FMB_ENERGY_FILTER_EN
          state_q <= S_RD_E;
          addr_q  <= entry_addr(E_BASE, idx_q);
`else
          state_q <= S_EVAL;
`endif
        end
        S_RD_E: state_q <= S_EVAL;
        S_EVAL: begin
          if (accept) begin
            valid_q <= 1'b1;
            bq_q    <= cand_q_q;
            bhops_q <= cand_hops_q;
            bid_q   <= cand_id_q;
            bidx_q  <= idx_q;
          end
          if (is_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RD_ID;
            idx_q   <= idx_d;
            addr_q  <= entry_addr(ID_BASE, idx_d);
          end
        end
        S_DONE: begin
          state_q <= S_ARMED;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address       = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign best_valid    = valid_q;
  assign best_id       = bid_q;
  assign best_q        = bq_q;
  assign best_hops     = bhops_q;
  assign best_idx      = bidx_q;
  assign count_clamped = clamped_q;

endmodule
